// File: rtl/tsmap_lookup.sv
// rtl/tsmap_lookup.sv - revocation-bit lookup over the TSMAP read port
// Maps a capability base address to a TSMAP word/bit, keeping one cached word for repeat lookups.

module tsmap_lookup #(
  parameter logic [31:0] HeapBase = 32'h8000_0000,
  parameter logic [31:0] HeapSize = 32'h0004_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_req_i,
  input  logic [31:0] lookup_addr_i,
  output logic        lookup_gnt_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_revoked_o,
  output logic        resp_inrange_o,
  input  logic        cache_inv_i,
  output logic        tsmap_cs_o,
  output logic [15:0] tsmap_addr_o,
  input  logic [31:0] tsmap_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  bidx_q;
  logic [15:0] widx_q;
  logic        inv_seen_q;
  logic        cache_valid_q;
  logic [15:0] cache_tag_q;
  logic [31:0] cache_word_q;
  logic        resp_valid_q;
  logic        resp_revoked_q;
  logic        resp_inrange_q;
  logic        tsmap_cs_q;
  logic [15:0] tsmap_addr_q;

  logic [31:0] req_off;
  logic [15:0] req_widx;
  logic [4:0]  req_bidx;
  logic        req_inrange;
  logic        req_hit;

  // Addresses below the heap wrap to a huge offset and fail the single compare.
  always_comb begin
    req_off     = lookup_addr_i - HeapBase;
    req_inrange = (req_off < HeapSize);
    req_widx    = req_off[23:8];
    req_bidx    = req_off[7:3];
    req_hit     = cache_valid_q && (cache_tag_q == req_widx) && !cache_inv_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      bidx_q         <= '0;
      widx_q         <= '0;
      inv_seen_q     <= 1'b0;
      cache_valid_q  <= 1'b0;
      cache_tag_q    <= '0;
      cache_word_q   <= '0;
      resp_valid_q   <= 1'b0;
      resp_revoked_q <= 1'b0;
      resp_inrange_q <= 1'b0;
      tsmap_cs_q     <= 1'b0;
      tsmap_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lookup_req_i) begin
            widx_q     <= req_widx;
            bidx_q     <= req_bidx;
            inv_seen_q <= 1'b0;
            if (!req_inrange) begin
              resp_valid_q   <= 1'b1;
              resp_revoked_q <= 1'b0;
              resp_inrange_q <= 1'b0;
              state_q        <= RESP;
            end else if (req_hit) begin
              resp_valid_q   <= 1'b1;
              resp_revoked_q <= cache_word_q[req_bidx];
              resp_inrange_q <= 1'b1;
              state_q        <= RESP;
            end else begin
              tsmap_cs_q   <= 1'b1;
              tsmap_addr_q <= req_widx;
              state_q      <= RD;
            end
          end
        end
        RD: begin
          tsmap_cs_q <= 1'b0;
          if (cache_inv_i) begin
            inv_seen_q <= 1'b1;
          end
          state_q <= CAP;
        end
        CAP: begin
          resp_valid_q   <= 1'b1;
          resp_revoked_q <= tsmap_rdata_i[bidx_q];
          resp_inrange_q <= 1'b1;
          // A word read across an invalidation may be stale, so it is used once but not kept.
          if (!inv_seen_q && !cache_inv_i) begin
            cache_word_q  <= tsmap_rdata_i;
            cache_tag_q   <= widx_q;
            cache_valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (cache_inv_i) begin
        cache_valid_q <= 1'b0;
      end
    end
  end

  assign lookup_gnt_o   = (state_q == IDLE) && !rst_i;
  assign resp_valid_o   = resp_valid_q;
  assign resp_revoked_o = resp_revoked_q;
  assign resp_inrange_o = resp_inrange_q;
  assign tsmap_cs_o     = tsmap_cs_q;
  assign tsmap_addr_o   = tsmap_addr_q;

endmodule

// File: tb/tb_tsmap_lookup.sv
// tb/tb_tsmap_lookup.sv - self-checking bench for tsmap_lookup
// Random and directed lookups compared against an address-arithmetic model with a one-word cache.

module tb_tsmap_lookup;

  localparam logic [31:0] HEAP_BASE = 32'h8000_0000;
  localparam logic [31:0] HEAP_SIZE = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        valid;
  logic        ready;
  logic        revoked;
  logic        inrange;
  logic        inv;
  logic        cs;
  logic [15:0] cs_addr;
  logic [31:0] rdata;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  bit          model_valid;
  logic [15:0] model_tag;

  int          r_lat;
  int          r_cs_cnt;
  logic [15:0] r_cs_addr;
  logic        r_rev;
  logic        r_inr;
  logic        r_gnt_acc;
  logic        r_valid_after;
  logic        r_gnt_after;
  bit          r_stable;

  tsmap_lookup dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lookup_req_i   (req),
    .lookup_addr_i  (addr),
    .lookup_gnt_o   (gnt),
    .resp_valid_o   (valid),
    .resp_ready_i   (ready),
    .resp_revoked_o (revoked),
    .resp_inrange_o (inrange),
    .cache_inv_i    (inv),
    .tsmap_cs_o     (cs),
    .tsmap_addr_o   (cs_addr),
    .tsmap_rdata_i  (rdata)
  );

  always #5 clk = ~clk;

  // 1-cycle TSMAP port; garbage whenever no read was strobed.
  always @(posedge clk) rdata <= cs ? mem[cs_addr[9:0]] : $urandom;

  function automatic void model_lookup(input logic [31:0] a, output bit inr,
                                       output logic [15:0] w, output bit rev);
    logic [31:0] off;
    logic [31:0] word;
    int b;
    off  = a - HEAP_BASE;
    inr  = (off < HEAP_SIZE);
    w    = 16'((off / 256) % 65536);
    b    = int'((off % 256) / 8);
    rev  = 1'b0;
    if (inr) begin
      word = mem[w[9:0]];
      rev  = word[b];
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    bit inr, rev;
    logic [15:0] w;
    model_lookup(a, inr, w, rev);
    return inr && model_valid && (model_tag == w);
  endfunction

  task automatic model_after(input logic [31:0] a, input int inv_cyc);
    bit inr, rev, hit;
    logic [15:0] w;
    int lat;
    model_lookup(a, inr, w, rev);
    hit = inr && model_valid && (model_tag == w);
    lat = (!inr || hit) ? 1 : 3;
    if (inr && !hit && !(inv_cyc >= 1 && inv_cyc <= 2)) begin
      model_valid = 1'b1;
      model_tag   = w;
    end
    if (inv_cyc >= 1 && inv_cyc <= lat) model_valid = 1'b0;
  endtask

  // Entered and left at a negedge with the DUT idle; inv_cyc pulses cache_inv_i in cycle T+inv_cyc.
  task automatic run_lookup(input logic [31:0] a, input int inv_cyc, input int hold);
    int cyc;
    r_cs_cnt  = 0;
    r_cs_addr = '0;
    r_lat     = 0;
    r_stable  = 1'b1;
    req       = 1'b1;
    addr      = a;
    r_gnt_acc = gnt;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    addr = $urandom;
    cyc = 1;
    while (cyc <= 10) begin
      inv = (cyc == inv_cyc);
      if (cs) begin
        r_cs_cnt++;
        r_cs_addr = cs_addr;
      end
      if (valid) begin
        r_lat = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    r_rev = revoked;
    r_inr = inrange;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      inv = 1'b0;
      if (valid !== 1'b1 || revoked !== r_rev || inrange !== r_inr || gnt !== 1'b0 || cs !== 1'b0)
        r_stable = 1'b0;
    end
    ready = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    ready = 1'b0;
    r_valid_after = valid;
    r_gnt_after   = gnt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, valid, revoked, inrange, cs} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt,valid,rev,inr,cs=%b required 00000", {gnt, valid, revoked, inrange, cs});
    end
    checks++;
    if (cs_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_tsmap_addr: got %h required 0000", cs_addr);
    end
    rst = 1'b0;
    model_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_gnt_after: got %b required 1", gnt);
    end
  endtask

  task automatic test_miss_then_hit;
    mem[1] = 32'h0000_0002;
    run_lookup(32'h8000_0108, 0, 0);
    model_after(32'h8000_0108, 0);
    checks++;
    if (r_lat !== 3 || r_cs_cnt !== 1 || r_cs_addr !== 16'h1) begin
      errors++;
      $display("FAIL miss_timing: got lat=%0d cs=%0d addr=%h required lat=3 cs=1 addr=0001", r_lat, r_cs_cnt, r_cs_addr);
    end
    checks++;
    if (r_rev !== 1'b1 || r_inr !== 1'b1 || r_gnt_acc !== 1'b1) begin
      errors++;
      $display("FAIL miss_data: got rev=%b inr=%b gnt=%b required 1 1 1", r_rev, r_inr, r_gnt_acc);
    end
    checks++;
    if (r_valid_after !== 1'b0 || r_gnt_after !== 1'b1) begin
      errors++;
      $display("FAIL miss_release: got valid=%b gnt=%b required 0 1", r_valid_after, r_gnt_after);
    end
    run_lookup(32'h8000_0108, 0, 0);
    model_after(32'h8000_0108, 0);
    checks++;
    if (r_lat !== 1 || r_cs_cnt !== 0 || r_rev !== 1'b1 || r_inr !== 1'b1) begin
      errors++;
      $display("FAIL hit: got lat=%0d cs=%0d rev=%b inr=%b required 1 0 1 1", r_lat, r_cs_cnt, r_rev, r_inr);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] oor [2];
    oor[0] = 32'h7FFF_FFF8;
    oor[1] = 32'h8004_0000;
    for (int i = 0; i < 2; i++) begin
      run_lookup(oor[i], 0, 0);
      model_after(oor[i], 0);
      checks++;
      if (r_lat !== 1 || r_cs_cnt !== 0 || r_inr !== 1'b0 || r_rev !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range %h: got lat=%0d cs=%0d inr=%b rev=%b required 1 0 0 0", oor[i], r_lat, r_cs_cnt, r_inr, r_rev);
      end
    end
  endtask

  task automatic test_window_edges;
    mem[0]     = 32'h0000_0001;
    mem[10'h3FF] = 32'h8000_0000;
    run_lookup(32'h8000_0000, 0, 0);
    model_after(32'h8000_0000, 0);
    checks++;
    if (r_cs_addr !== 16'h0 || r_rev !== 1'b1 || r_inr !== 1'b1 || r_lat !== 3) begin
      errors++;
      $display("FAIL edge_low: got addr=%h rev=%b inr=%b lat=%0d required 0000 1 1 3", r_cs_addr, r_rev, r_inr, r_lat);
    end
    run_lookup(32'h8000_0008, 0, 0);
    model_after(32'h8000_0008, 0);
    checks++;
    if (r_lat !== 1 || r_rev !== 1'b0) begin
      errors++;
      $display("FAIL edge_low_bit1: got lat=%0d rev=%b required 1 0", r_lat, r_rev);
    end
    run_lookup(32'h8003_FFF8, 0, 0);
    model_after(32'h8003_FFF8, 0);
    checks++;
    if (r_cs_addr !== 16'h03FF || r_rev !== 1'b1 || r_inr !== 1'b1 || r_lat !== 3) begin
      errors++;
      $display("FAIL edge_high: got addr=%h rev=%b inr=%b lat=%0d required 03ff 1 1 3", r_cs_addr, r_rev, r_inr, r_lat);
    end
  endtask

  task automatic test_invalidate;
    run_lookup(32'h8000_0108, 0, 0);
    model_after(32'h8000_0108, 0);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    model_valid = 1'b0;
    run_lookup(32'h8000_0100, 0, 0);
    model_after(32'h8000_0100, 0);
    checks++;
    if (r_lat !== 3 || r_cs_cnt !== 1 || r_rev !== mem[1][0]) begin
      errors++;
      $display("FAIL inv_idle: got lat=%0d cs=%0d rev=%b required 3 1 %b", r_lat, r_cs_cnt, r_rev, mem[1][0]);
    end
    mem[2] = $urandom | 32'h1;
    run_lookup(32'h8000_0200, 2, 0);
    model_after(32'h8000_0200, 2);
    checks++;
    if (r_lat !== 3 || r_rev !== 1'b1) begin
      errors++;
      $display("FAIL inv_cap_resp: got lat=%0d rev=%b required 3 1", r_lat, r_rev);
    end
    run_lookup(32'h8000_0200, 0, 0);
    model_after(32'h8000_0200, 0);
    checks++;
    if (r_lat !== 3 || r_cs_cnt !== 1) begin
      errors++;
      $display("FAIL inv_cap_nofill: got lat=%0d cs=%0d required 3 1", r_lat, r_cs_cnt);
    end
    run_lookup(32'h8000_0500, 1, 0);
    model_after(32'h8000_0500, 1);
    run_lookup(32'h8000_0500, 0, 0);
    model_after(32'h8000_0500, 0);
    checks++;
    if (r_lat !== 3 || r_cs_cnt !== 1) begin
      errors++;
      $display("FAIL inv_rd_nofill: got lat=%0d cs=%0d required 3 1", r_lat, r_cs_cnt);
    end
  endtask

  task automatic test_backpressure;
    run_lookup(32'h8000_0108, 0, 5);
    model_after(32'h8000_0108, 0);
    checks++;
    if (r_stable !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_stable: got %b required 1", r_stable);
    end
    checks++;
    if (r_valid_after !== 1'b0 || r_gnt_after !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b gnt=%b required 0 1", r_valid_after, r_gnt_after);
    end
  endtask

  task automatic test_reset_mid_miss;
    bit quiet;
    run_lookup(32'h8000_0300, 0, 0);
    model_after(32'h8000_0300, 0);
    req  = 1'b1;
    addr = 32'h8000_0400;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (cs !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rd_cs: got %b required 1", cs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cs !== 1'b0 || valid !== 1'b0 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got cs=%b valid=%b gnt=%b required 0 0 0", cs, valid, gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_valid = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || cs !== 1'b0 || gnt !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %b required 1", quiet);
    end
    run_lookup(32'h8000_0300, 0, 0);
    model_after(32'h8000_0300, 0);
    checks++;
    if (r_lat !== 3 || r_cs_cnt !== 1 || r_cs_addr !== 16'h3) begin
      errors++;
      $display("FAIL rst_mid_refetch: got lat=%0d cs=%0d addr=%h required 3 1 0003", r_lat, r_cs_cnt, r_cs_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    bit inr, rev, hit;
    logic [15:0] w;
    int kind, inv_cyc, hold, exp_lat, exp_cs;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        6:       a = HEAP_BASE + $urandom_range(0, HEAP_SIZE - 1);
        7:       a = HEAP_BASE - $urandom_range(1, 4096);
        8:       a = HEAP_BASE + HEAP_SIZE + $urandom_range(0, 4096);
        default: a = HEAP_BASE + $urandom_range(0, 8 * 256 - 1);
      endcase
      if (kind == 9) begin
        mem[$urandom_range(0, 7)] = $urandom;
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        model_valid = 1'b0;
      end
      inv_cyc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      hold    = $urandom_range(0, 2);
      model_lookup(a, inr, w, rev);
      hit     = model_hit(a);
      exp_lat = (!inr || hit) ? 1 : 3;
      exp_cs  = (inr && !hit) ? 1 : 0;
      run_lookup(a, inv_cyc, hold);
      model_after(a, inv_cyc);
      checks++;
      if (r_lat !== exp_lat || r_cs_cnt !== exp_cs || (exp_cs == 1 && r_cs_addr !== w)) begin
        errors++;
        $display("FAIL b2b_timing %h: got lat=%0d cs=%0d addr=%h required lat=%0d cs=%0d addr=%h",
                 a, r_lat, r_cs_cnt, r_cs_addr, exp_lat, exp_cs, w);
      end
      checks++;
      if (r_rev !== rev || r_inr !== inr) begin
        errors++;
        $display("FAIL b2b_data %h: got rev=%b inr=%b required rev=%b inr=%b", a, r_rev, r_inr, rev, inr);
      end
      checks++;
      if (r_gnt_acc !== 1'b1 || r_stable !== 1'b1 || r_valid_after !== 1'b0 || r_gnt_after !== 1'b1) begin
        errors++;
        $display("FAIL b2b_handshake %h: got gnt=%b stable=%b valid_after=%b gnt_after=%b required 1 1 0 1",
                 a, r_gnt_acc, r_stable, r_valid_after, r_gnt_after);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    addr  = '0;
    ready = 1'b0;
    inv   = 1'b0;
    model_valid = 1'b0;
    model_tag   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset;
    test_miss_then_hit;
    test_out_of_range;
    test_window_edges;
    test_invalidate;
    test_backpressure;
    test_reset_mid_miss;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
